controller_reciprocal: RTL

FSM controller that sequences the N-bit Newton-Raphson reciprocal datapath (r register, shared shift-add multiplier, 4-bit iteration counter).
Per request it initialises r to 1.0, then runs ITERS iterations of r <- r*(2 - r*x), using the multiplier twice per iteration.
It drives every datapath control line and reports busy/done/err to the host.
Top-level reciprocal unit = this block + datapath, joined by the control lines below.

---
 rtl/reciprocal_pkg.sv | 30 +++
 rtl/controller_reciprocal_wait_timer.sv | 38 +++
 rtl/controller_reciprocal.sv | 110 +++++++++++
 3 files changed

// File: rtl/reciprocal_pkg.sv
// Shared types and constants for the Newton-Raphson reciprocal unit.
// Imported by the controller and its wait timer.
package reciprocal_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    M1_START,
    M1_WAIT,
    M2_START,
    M2_WAIT,
    UPDATE,
    CHECK,
    DONE,
    ABORT
  } state_t;

  localparam logic SEL_R_ONE   = 1'b0;
  localparam logic SEL_R_PROD  = 1'b1;
  localparam logic SEL_OP_RX   = 1'b1;
  localparam logic SEL_OP_CORR = 1'b0;

  localparam int ITERS_DEF   = 4;
  localparam int TIMEOUT_DEF = 64;

  function automatic int tmr_w(input int t);
    return (t <= 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/controller_reciprocal_wait_timer.sv
// Wait-state watchdog: cleared on entry, counts while enabled,
// flags expiry once the count has reached TIMEOUT-1.
module wait_timer
  import reciprocal_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = tmr_w(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !expired_o)
      cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/controller_reciprocal.sv
// Sequencer for the Newton-Raphson reciprocal datapath:
// r <- 1.0, then ITERS rounds of r <- r*(2 - r*x) on a shared multiplier.
module controller_reciprocal
  import reciprocal_pkg::*;
#(
  parameter int ITERS   = ITERS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic       ready,
  input  logic [3:0] co,
  output logic       cload,
  output logic       cen,
  output logic       load,
  output logic       start,
  output logic [1:2] s,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] LAST_IT = 4'(ITERS);

  state_t state_q, state_d;
  logic   tmr_clr, tmr_en, tmr_exp;

  assign tmr_clr = (state_q == M1_START) || (state_q == M2_START);
  assign tmr_en  = (state_q == M1_WAIT)  || (state_q == M2_WAIT);

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_tmr (
    .clk_i    (clock),
    .rst_i    (reset),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expired_o(tmr_exp)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (go) state_d = INIT;
      INIT:     state_d = M1_START;
      M1_START: state_d = M1_WAIT;
      M1_WAIT: begin
        if (ready)        state_d = M2_START;
        else if (tmr_exp) state_d = ABORT;
      end
      M2_START: state_d = M2_WAIT;
      M2_WAIT: begin
        if (ready)        state_d = UPDATE;
        else if (tmr_exp) state_d = ABORT;
      end
      UPDATE:   state_d = CHECK;
      // co already reflects the increment issued in UPDATE
      CHECK:    state_d = (co == LAST_IT) ? DONE : M1_START;
      DONE:     state_d = IDLE;
      ABORT:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cload = 1'b0;
    cen   = 1'b0;
    load  = 1'b0;
    start = 1'b0;
    s     = 2'b00;
    done  = 1'b0;
    err   = 1'b0;
    busy  = (state_q != IDLE);
    unique case (state_q)
      INIT: begin
        s[1]  = SEL_R_ONE;
        load  = 1'b1;
        cload = 1'b1;
      end
      M1_START: begin
        s[2]  = SEL_OP_RX;
        start = 1'b1;
      end
      M1_WAIT:  s[2] = SEL_OP_RX;
      M2_START: begin
        s[2]  = SEL_OP_CORR;
        start = 1'b1;
      end
      M2_WAIT:  s[2] = SEL_OP_CORR;
      UPDATE: begin
        s[1] = SEL_R_PROD;
        s[2] = SEL_OP_CORR;
        load = 1'b1;
        cen  = 1'b1;
      end
      DONE:     done = 1'b1;
      ABORT:    err  = 1'b1;
      default: ;
    endcase
  end

endmodule
